// File: rtl/sha256_digest_tx.sv
// sha256_digest_tx
// Latches one 256-bit digest and streams it MSB-first over a valid/ready byte
// interface. It can send the digest as lowercase ASCII hex or as raw bytes, and
// can optionally add CR LF. A one-cycle done pulse marks the end of each frame.
module sha256_digest_tx #(
  parameter bit HEX_ASCII   = 1'b1,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] digest_in,
  input  logic         digest_valid,
  output logic         digest_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_CR,
    ST_LF,
    ST_FIN
  } state_t;

  // Index of the last digest symbol: 64 nibbles in hex mode, 32 bytes in raw mode
  localparam logic [6:0] LAST_IDX = HEX_ASCII ? 7'd63 : 7'd31;

  state_t       state;
  state_t       state_next;
  logic [255:0] shreg;
  logic [6:0]   cnt;
  logic         accept;
  logic         xfer;
  logic [3:0]   nibble;
  logic [7:0]   hex_char;

  assign accept = digest_valid & digest_ready;
  assign xfer   = tx_valid & tx_ready;
  assign nibble = shreg[255:252];

  // Map the leading nibble to a lowercase ASCII hex character ('0'-'9', 'a'-'f')
  assign hex_char = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                     : (8'h57 + {4'h0, nibble});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Digest shift register and symbol counter: load on accept, advance one symbol per transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= digest_in;
      cnt   <= '0;
    end else if ((state == ST_SEND) && xfer) begin
      if (HEX_ASCII) begin
        shreg <= {shreg[251:0], 4'h0};
      end else begin
        shreg <= {shreg[247:0], 8'h00};
      end
      cnt <= cnt + 7'd1;
    end
  end

  // Next-state logic: each stage advances only on a completed byte transfer
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer && (cnt == LAST_IDX)) begin
          if (APPEND_CRLF) begin
            state_next = ST_CR;
          end else begin
            state_next = ST_FIN;
          end
        end
      end
      ST_CR: begin
        if (xfer) begin
          state_next = ST_LF;
        end
      end
      ST_LF: begin
        if (xfer) begin
          state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        if (accept) begin
          state_next = ST_SEND;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs depend only on state and shreg, so tx_ready has no combinational path to tx_data
  always_comb begin
    digest_ready = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    done         = 1'b0;
    case (state)
      ST_IDLE: begin
        digest_ready = 1'b1;
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        if (HEX_ASCII) begin
          tx_data = hex_char;
        end else begin
          tx_data = shreg[255:248];
        end
      end
      ST_CR: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
      end
      ST_LF: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
      end
      ST_FIN: begin
        done         = 1'b1;
        digest_ready = 1'b1;
      end
      default: begin
        digest_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sha256_digest_tx.sv
// Testbench for sha256_digest_tx. It drives a hex+CRLF instance and a raw
// instance without a terminator. Expected byte streams come from the digest
// itself, formatted as text or sliced into bytes.
module tb_sha256_digest_tx;

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] NIBBLE_DIGEST = {4{64'h0123456789abcdef}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] dig  [2];
  logic         dv   [2];
  logic         rdy  [2];
  logic [7:0]   txd  [2];
  logic         txv  [2];
  logic         txr  [2];
  logic         done [2];

  int total = 0;
  int bad   = 0;

  logic [7:0] cap0 [$];
  logic [7:0] cap1 [$];
  logic [7:0] expq [$];

  int         done_cnt   [2];
  int         stall_err  [2];
  int         fin_err    [2];
  bit         prev_stall [2];
  bit [7:0]   prev_data  [2];
  bit         prev_done  [2];

  always #5 clk = ~clk;

  sha256_digest_tx #(.HEX_ASCII(1'b1), .APPEND_CRLF(1'b1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .digest_in(dig[0]), .digest_valid(dv[0]),
    .digest_ready(rdy[0]), .tx_data(txd[0]), .tx_valid(txv[0]),
    .tx_ready(txr[0]), .done(done[0])
  );

  sha256_digest_tx #(.HEX_ASCII(1'b0), .APPEND_CRLF(1'b0)) dut_raw (
    .clk(clk), .rst_n(rst_n), .digest_in(dig[1]), .digest_valid(dv[1]),
    .digest_ready(rdy[1]), .tx_data(txd[1]), .tx_valid(txv[1]),
    .tx_ready(txr[1]), .done(done[1])
  );

  // Watch both byte interfaces mid-cycle: capture transfers, count done pulses,
  // and note any stall that changed data or any malformed done cycle
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (txv[d] === 1'b1 && txr[d] === 1'b1) begin
        if (d == 0) cap0.push_back(txd[d]);
        else        cap1.push_back(txd[d]);
      end
      if (prev_stall[d] && (txv[d] !== 1'b1 || txd[d] !== prev_data[d]))
        stall_err[d] <= stall_err[d] + 1;
      if (done[d] === 1'b1) begin
        done_cnt[d] <= done_cnt[d] + 1;
        if (rdy[d] !== 1'b1 || txv[d] !== 1'b0 || prev_done[d])
          fin_err[d] <= fin_err[d] + 1;
      end
      prev_stall[d] <= (txv[d] === 1'b1) && (txr[d] !== 1'b1) && (rst_n === 1'b1);
      prev_data[d]  <= txd[d];
      prev_done[d]  <= (done[d] === 1'b1);
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int cap_size(input int d);
    return (d == 0) ? cap0.size() : cap1.size();
  endfunction

  function automatic logic [7:0] cap_at(input int d, input int i);
    return (d == 0) ? cap0[i] : cap1[i];
  endfunction

  function automatic logic [255:0] rand_digest();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit rand_ready(input int duty);
    return int'($urandom_range(0, 99)) < duty;
  endfunction

  // Reference frame: hex mode is the digest's %h text, raw mode is its bytes from the top
  task automatic add_expected(input logic [255:0] dg, input bit hex, input bit crlf);
    string s;
    if (hex) begin
      s = $sformatf("%h", dg);
      for (int i = 0; i < 64; i++) expq.push_back(s[i]);
    end else begin
      for (int i = 0; i < 32; i++) expq.push_back(dg[255-8*i -: 8]);
    end
    if (crlf) begin
      expq.push_back(8'h0D);
      expq.push_back(8'h0A);
    end
  endtask

  // Present a digest and check the one-cycle latency to the first tx_valid
  task automatic applyStimulus(input int d, input logic [255:0] dg,
                               input logic [255:0] next_dg, input bit chain,
                               input int duty);
    @(posedge clk); #1;
    dig[d] = dg;
    dv[d]  = 1'b1;
    txr[d] = rand_ready(duty);
    @(negedge clk);
    checkOutput("ready_idle", rdy[d], 1);
    @(posedge clk); #1;
    if (chain) begin
      dig[d] = next_dg;
    end else begin
      dv[d]  = 1'b0;
      dig[d] = rand_digest();
    end
    txr[d] = rand_ready(duty);
    @(negedge clk);
    checkOutput("first_valid", txv[d], 1);
    checkOutput("ready_busy", rdy[d], 0);
  endtask

  task automatic stream_until_done(input int d, input int duty, input int ndone,
                                   input int busy_at, output int cycles);
    int base;
    base   = done_cnt[d];
    cycles = 0;
    while ((done_cnt[d] - base) < ndone && cycles < 5000) begin
      @(posedge clk); #1;
      if (busy_at >= 0 && cycles == busy_at) begin
        dv[d]  = 1'b1;
        dig[d] = '1;
      end else if (busy_at >= 0 && cycles == busy_at + 1) begin
        dv[d] = 1'b0;
      end
      if ((done_cnt[d] - base) > 0) dv[d] = 1'b0;
      txr[d] = rand_ready(duty);
      cycles++;
    end
    checkOutput("done_seen", (done_cnt[d] - base) == ndone, 1);
  endtask

  task automatic compare_capture(input int d, input int cb, input string name);
    int n;
    n = cap_size(d) - cb;
    checkOutput({name, "_len"}, n, expq.size());
    for (int i = 0; i < expq.size() && i < n; i++)
      checkOutput($sformatf("%s_b%0d", name, i), cap_at(d, cb + i), expq[i]);
  endtask

  task automatic run_frame(input int d, input logic [255:0] dg, input int duty,
                           input int busy_at, input string name);
    int cb, sb, fb, cycles;
    cb = cap_size(d);
    sb = stall_err[d];
    fb = fin_err[d];
    expq.delete();
    add_expected(dg, d == 0, d == 0);
    applyStimulus(d, dg, '0, 1'b0, duty);
    stream_until_done(d, duty, 1, busy_at, cycles);
    compare_capture(d, cb, name);
    checkOutput({name, "_stall"}, stall_err[d] - sb, 0);
    checkOutput({name, "_fin"}, fin_err[d] - fb, 0);
    if (duty >= 100) checkOutput({name, "_cycles"}, cycles, expq.size() + 1);
  endtask

  initial begin
    int cb, fb, cycles, k;
    logic [255:0] dg1, dg2;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      dig[d] = '0;
      dv[d]  = 1'b0;
      txr[d] = 1'b0;
    end
    #3;
    for (int d = 0; d < 2; d++) begin
      checkOutput("rst_valid", txv[d], 0);
      checkOutput("rst_ready", rdy[d], 1);
      checkOutput("rst_done", done[d], 0);
      checkOutput("rst_data", txd[d], 0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_frame(0, ABC_DIGEST, 100, -1, "hex_abc");
    run_frame(1, ABC_DIGEST, 100, -1, "raw_abc");
    run_frame(0, ABC_DIGEST, 30, -1, "hex_bp");
    run_frame(0, rand_digest(), 100, 20, "hex_busy");
    run_frame(1, rand_digest(), 60, 10, "raw_busy");
    run_frame(0, NIBBLE_DIGEST, 100, -1, "hex_nib");

    // A second digest held during the first frame is taken in the done cycle, with no gap
    dg1 = rand_digest();
    dg2 = rand_digest();
    cb  = cap_size(0);
    fb  = fin_err[0];
    expq.delete();
    add_expected(dg1, 1'b1, 1'b1);
    add_expected(dg2, 1'b1, 1'b1);
    applyStimulus(0, dg1, dg2, 1'b1, 100);
    stream_until_done(0, 100, 2, -1, cycles);
    compare_capture(0, cb, "chain");
    checkOutput("chain_cycles", cycles, expq.size() + 2);
    checkOutput("chain_fin", fin_err[0] - fb, 0);

    // Reset partway through a frame aborts it; the next frame starts clean
    cb = cap_size(0);
    applyStimulus(0, rand_digest(), '0, 1'b0, 100);
    k = 0;
    while ((cap_size(0) - cb) < 10 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("reached_byte10", (cap_size(0) - cb) >= 10, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", txv[0], 0);
    checkOutput("midrst_ready", rdy[0], 1);
    checkOutput("midrst_done", done[0], 0);
    @(negedge clk);
    checkOutput("midrst_hold", txv[0], 0);
    rst_n = 1'b1;
    run_frame(0, '0, 100, -1, "hex_zero");

    // Random digests with random back-pressure on both instances
    for (int i = 0; i < 4; i++) begin
      run_frame(0, rand_digest(), $urandom_range(20, 100), -1, $sformatf("rh%0d", i));
      run_frame(1, rand_digest(), $urandom_range(20, 100), -1, $sformatf("rr%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_digest_tx.md
Name: sha256_digest_tx

Overview:
Transmit-side counterpart of the byte-receive/message-assembly path. Accepts one 256-bit SHA-256 digest from the hash core, latches it, and streams it MSB-first as bytes toward the UART transmitter over a valid/ready byte handshake. The digest goes out either as lowercase ASCII hex (64 characters) or as raw binary (32 bytes), optionally followed by CR LF. Sits between the sha256 core output and the UART TX byte interface.

Parameters:
HEX_ASCII, 1, 1 = emit 64 lowercase ASCII hex characters; 0 = emit 32 raw bytes
APPEND_CRLF, 1, 1 = append 0x0D then 0x0A after the digest bytes; 0 = no terminator

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
digest_in  input  256  digest from the hash core; bits [255:248] are the first byte
digest_valid  input  1  digest_in is valid; accepted only when digest_ready=1
digest_ready  output  1  block is idle and can accept a digest
tx_data  output  8  byte presented to the UART TX
tx_valid  output  1  tx_data is valid
tx_ready  input  1  UART TX accepts tx_data this cycle
done  output  1  one-cycle pulse after the final byte handshake

Behaviour:
- Reset (async assert, sync release): state=IDLE, digest_ready=1, tx_valid=0, tx_data=8'h00, done=0, shift register and counter cleared.
- Handshakes: digest accept = digest_valid & digest_ready. Byte transfer = tx_valid & tx_ready.
- States:
  - IDLE: digest_ready=1. On accept, latch digest_in into a 256-bit shift register, clear the counter, and go to SEND. digest_ready drops and tx_valid rises in the next cycle. Latency from accept to first tx_valid is 1 cycle.
  - SEND: tx_valid=1.
    - HEX_ASCII=1: tx_data = ASCII of shreg[255:252]. Nibbles 0-9 map to 0x30-0x39; nibbles a-f map to 0x61-0x66.
    - HEX_ASCII=0: tx_data = shreg[255:248].
    - On each transfer, shift left 4 bits (hex) or 8 bits (raw) and increment the counter.
    - After the 64th (hex) or 32nd (raw) transfer, go to CR if APPEND_CRLF=1, otherwise go to FIN.
  - CR: tx_valid=1, tx_data=0x0D. On transfer, go to LF.
  - LF: tx_valid=1, tx_data=0x0A. On transfer, go to FIN.
  - FIN: tx_valid=0, done=1 for exactly one cycle, digest_ready=1 in the same cycle. Next cycle go to IDLE. A digest accepted during FIN starts a new frame.
- Data stability: while tx_valid=1 and tx_ready=0, tx_data and the state must hold unchanged. tx_valid never drops before its transfer completes.
- Throughput: with tx_ready held at 1, one byte per cycle with no bubbles between the digest, CR and LF.
- tx_data is driven from registers; no combinational path from tx_ready to tx_data.
- digest_valid while digest_ready=0 is ignored and the frame in progress is unaffected. The hash core must hold the digest until it is accepted.
- Counter is 7 bits, giving a maximum frame of 66 bytes.
- Frame length: 66 bytes (hex + CRLF), 64 (hex), 34 (raw + CRLF), or 32 (raw).
- Reset asserted mid-frame aborts immediately to the reset values. The partial frame is never resumed.
- tx_ready asserted while tx_valid=0 has no effect.

Test Plan:
- HEX_ASCII=1, APPEND_CRLF=1, digest "abc" = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, tx_ready tied 1 -> 66 consecutive bytes: 0x62,0x61,0x37,0x38 ... 0x61,0x64,0x0D,0x0A. First tx_valid 1 cycle after accept. done pulses once, 1 cycle after the 0x0A transfer.
- HEX_ASCII=0, APPEND_CRLF=0, same digest -> 32 bytes 0xBA,0x78,0x16 ... 0x15,0xAD, no terminator, done after byte 32.
- Backpressure: tx_ready random ~30% duty in hex mode -> identical 66-byte sequence; tx_data/tx_valid stable throughout every stall.
- Busy-time input: pulse digest_valid with digest all-ones mid-frame -> ignored, original frame unchanged. A new digest presented during the done cycle is accepted and its frame follows immediately.
- Reset at byte 10 of a frame -> tx_valid=0, digest_ready=1, done=0 immediately. A following digest 00..00 produces 64 × 0x30 then 0x0D,0x0A.
- Nibble coverage: digest 0123456789abcdef repeated 4× -> characters 0x30-0x39 then 0x61-0x66, repeating.
